// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, cancel, op, a, b, input busy, done, result);
  modport slave  (input start, cancel, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of a WIDTH-bit value.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider
// sharing one hi:lo accumulator, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q, result_q;
  logic             sgn_x_q, sgn_a_q;

  logic             accept, last, busy_c, done_c;
  logic             a_signed, b_signed, a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, ovf, special;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   sum, acc, shl;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] hi_n, lo_n, hi_fix, lo_fix, mul_hi, final_res;

  assign accept = (state != CALC) && bus.start && !bus.cancel;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Operand signedness and magnitudes, evaluated on the request inputs.
  assign a_signed = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
  assign b_signed = a_signed && (bus.op != OP_MULHSU);
  assign a_sgn    = a_signed && bus.a[WIDTH-1];
  assign b_sgn    = b_signed && bus.b[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.en(a_sgn), .din(bus.a), .dout(a_mag));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.en(b_sgn), .din(bus.b), .dout(b_mag));

  // Divide-by-zero and signed overflow are answered without iterating.
  assign div_zero = is_div(bus.op) && (bus.b == '0);
  assign ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.a == MIN_NEG) && (bus.b == '1);
  assign special  = div_zero || ovf;

  // Fixed answers for the bypass cases; funct3[1] selects remainder.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = bus.op[1] ? bus.a : '1;
    else if (ovf) special_res = bus.op[1] ? '0 : bus.a;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, mcand_q};
    acc  = lo_q[0] ? sum : {1'b0, hi_q};
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = {1'b0, shl} - {2'b00, mcand_q};
    hi_n = acc[WIDTH:1];
    lo_n = {acc[0], lo_q[WIDTH-1:1]};
    if (is_div(op_q)) begin
      if (!diff[WIDTH+1]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shl[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix folded into the last step: lo carries product-low or quotient,
  // hi carries product-high or remainder.
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_lo (
    .en(sgn_x_q), .din(lo_n), .dout(lo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_hi (
    .en(is_div(op_q) ? sgn_a_q : sgn_x_q), .din(hi_n), .dout(hi_fix));

  // Negating a double-width product only carries into the high half when the low half is zero.
  assign mul_hi = (sgn_x_q && (lo_n != '0)) ? ~hi_n : hi_fix;

  // Select the architectural result for the latched op.
  always_comb begin
    final_res = lo_fix;
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_hi;
      OP_REM, OP_REMU:              final_res = hi_fix;
      default:                      final_res = lo_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (bus.cancel) state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = accept ? (special ? DONE : CALC) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, accumulator update while iterating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sgn_x_q  <= 1'b0;
      sgn_a_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= bus.op;
      mcand_q <= is_div(bus.op) ? b_mag : a_mag;
      lo_q    <= is_div(bus.op) ? a_mag : b_mag;
      hi_q    <= '0;
      sgn_x_q <= a_sgn ^ b_sgn;
      sgn_a_q <= a_sgn;
      if (special) result_q <= special_res;
    end else if (state == CALC && !bus.cancel) begin
      cnt  <= cnt + CNT_W'(1);
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (last) result_q <= final_res;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;

endmodule
